// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin sequencer sharing one signed ALU between two requesters
module alu_req_arbiter #(
  parameter int EXEC_CYCLES = 1,
  parameter int DZ_CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [2:0]          req0_a,
  input  logic [2:0]          req0_b,
  input  logic [1:0]          req0_sel,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [2:0]          req1_a,
  input  logic [2:0]          req1_b,
  input  logic [1:0]          req1_sel,
  output logic [2:0]          alu_a,
  output logic [2:0]          alu_b,
  output logic [1:0]          alu_s,
  input  logic [4:0]          alu_r,
  input  logic                alu_sf,
  input  logic                alu_zf,
  input  logic                alu_dzf,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [4:0]          rsp_r,
  output logic                rsp_sf,
  output logic                rsp_zf,
  output logic                rsp_dzf,
  output logic                busy,
  output logic [DZ_CNT_W-1:0] dz_count
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic [2:0] cnt;
  logic ptr, gnt1, take;
  // requester 1 wins when it is alone or when the pointer favours it
  assign gnt1 = req1_valid && (!req0_valid || ptr);
  assign take = state == IDLE && (req0_valid || req1_valid);
  assign req0_ready = take && !gnt1;
  assign req1_ready = take && gnt1;
  assign busy = state != IDLE;
  assign rsp_valid = state == RESP;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_s    <= '0;
      rsp_id   <= 1'b0;
      rsp_r    <= '0;
      rsp_sf   <= 1'b0;
      rsp_zf   <= 1'b0;
      rsp_dzf  <= 1'b0;
      dz_count <= '0;
    end else begin
      case (state)
        IDLE: if (take) begin
          alu_a  <= gnt1 ? req1_a : req0_a;
          alu_b  <= gnt1 ? req1_b : req0_b;
          alu_s  <= gnt1 ? req1_sel : req0_sel;
          rsp_id <= gnt1;
          ptr    <= !gnt1;
          cnt    <= 3'(EXEC_CYCLES - 1);
          state  <= EXEC;
        end
        EXEC: if (cnt == '0) begin
          rsp_r   <= alu_r;
          rsp_sf  <= alu_sf;
          rsp_zf  <= alu_zf;
          rsp_dzf <= alu_dzf;
          state   <= RESP;
        end else begin
          cnt <= cnt - 3'd1;
        end
        RESP: if (rsp_ready) begin
          state <= IDLE;
          if (rsp_dzf && !(&dz_count)) dz_count <= dz_count + DZ_CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: directed, table and randomized checks of the shared-ALU arbiter
module tb_alu_req_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic r0v = 0, r1v = 0, r0rdy, r1rdy, rspv, rsp_ready = 1, rid, rsf, rzf, rdzf, busy;
  logic [2:0] r0a = 0, r0b = 0, r1a = 0, r1b = 0, aa, ab;
  logic [1:0] r0s = 0, r1s = 0, as0;
  logic [4:0] ar, rr;
  logic asf, azf, adzf;
  logic [7:0] dz;
  logic ev = 0, erdy, e_r1rdy, e_rspv, e_id, e_rsf, e_rzf, e_rdzf, e_busy, e_asf, e_azf, e_adzf;
  logic [2:0] ea = 0, eb = 0, e_aa, e_ab;
  logic [1:0] es = 0, e_as;
  logic [4:0] e_ar, e_rr;
  logic [1:0] e_dz;
  int n_tests = 0, n_fail = 0;

  alu_req_arbiter u0 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v), .req0_ready(r0rdy), .req0_a(r0a), .req0_b(r0b), .req0_sel(r0s),
    .req1_valid(r1v), .req1_ready(r1rdy), .req1_a(r1a), .req1_b(r1b), .req1_sel(r1s),
    .alu_a(aa), .alu_b(ab), .alu_s(as0), .alu_r(ar), .alu_sf(asf), .alu_zf(azf), .alu_dzf(adzf),
    .rsp_valid(rspv), .rsp_ready(rsp_ready), .rsp_id(rid), .rsp_r(rr),
    .rsp_sf(rsf), .rsp_zf(rzf), .rsp_dzf(rdzf), .busy(busy), .dz_count(dz)
  );

  alu_req_arbiter #(.EXEC_CYCLES(3), .DZ_CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(ev), .req0_ready(erdy), .req0_a(ea), .req0_b(eb), .req0_sel(es),
    .req1_valid(1'b0), .req1_ready(e_r1rdy), .req1_a(3'd0), .req1_b(3'd0), .req1_sel(2'd0),
    .alu_a(e_aa), .alu_b(e_ab), .alu_s(e_as), .alu_r(e_ar), .alu_sf(e_asf), .alu_zf(e_azf), .alu_dzf(e_adzf),
    .rsp_valid(e_rspv), .rsp_ready(1'b1), .rsp_id(e_id), .rsp_r(e_rr),
    .rsp_sf(e_rsf), .rsp_zf(e_rzf), .rsp_dzf(e_rdzf), .busy(e_busy), .dz_count(e_dz)
  );

  // behavioural signed ALU, returns {dzf, zf, sf, r}
  function automatic logic [7:0] alu_fn(input logic [2:0] a, input logic [2:0] b, input logic [1:0] s);
    int x, y, z;
    logic [4:0] r;
    x = int'($signed(a));
    y = int'($signed(b));
    z = s == 2'd0 ? x + y : s == 2'd1 ? x - y : s == 2'd2 ? x * y : (y == 0 ? 0 : x % y);
    r = z[4:0];
    return {s == 2'd3 && y == 0, r == 5'd0, r[4], r};
  endfunction
  assign {adzf, azf, asf, ar} = alu_fn(aa, ab, as0);
  assign {e_adzf, e_azf, e_asf, e_ar} = alu_fn(e_aa, e_ab, e_as);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    #2;
    chk("one_ready", 32'(r0rdy & r1rdy), 0);
    chk("ready_only_idle", 32'((r0rdy | r1rdy) & busy), 0);
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; r0v = 0; r1v = 0; rsp_ready = 1;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic send(input logic id, input logic [2:0] a, input logic [2:0] b, input logic [1:0] s,
                      output logic [8:0] rsp, output int lat, output int w);
    @(negedge clk);
    if (id) {r1v, r1a, r1b, r1s} = {1'b1, a, b, s};
    else {r0v, r0a, r0b, r0s} = {1'b1, a, b, s};
    #1;
    w = 0;
    while (!(id ? r1rdy : r0rdy) && w < 20) begin @(negedge clk); #1; w++; end
    chk("grant_timeout", 32'(w < 20), 1);
    @(negedge clk);
    if (id) r1v = 0; else r0v = 0;
    lat = 1;
    while (!rspv && lat < 20) begin @(negedge clk); lat++; end
    chk("rsp_timeout", 32'(lat < 20), 1);
    rsp = {rid, rdzf, rzf, rsf, rr};
  endtask

  task automatic esend(input logic [2:0] a, input logic [2:0] b, input logic [1:0] s,
                       output logic [7:0] rsp, output int lat);
    int w;
    @(negedge clk);
    {ev, ea, eb, es} = {1'b1, a, b, s};
    #1;
    w = 0;
    while (!erdy && w < 20) begin @(negedge clk); #1; w++; end
    chk("e_grant_timeout", 32'(w < 20), 1);
    @(negedge clk);
    ev = 0;
    lat = 1;
    while (!e_rspv && lat < 20) begin @(negedge clk); lat++; end
    chk("e_rsp_timeout", 32'(lat < 20), 1);
    rsp = {e_rdzf, e_rzf, e_rsf, e_rr};
  endtask

  typedef struct {
    logic id; logic [2:0] a, b; logic [1:0] s;
    logic [4:0] r; logic sf, zf, dzf;
  } vec_t;
  vec_t tbl[8];

  initial begin
    logic [8:0] rsp, snap;
    logic [7:0] ersp, dz0;
    logic [8:0] q[$];
    int lat, w, t, dz_m;
    bit free, ptr_m, h0, h1, g1, e0, e1;
    tbl[0] = '{1'b0, 3'd3, 3'd6, 2'd0, 5'b00001, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 3'd5, 3'd3, 2'd2, 5'b10111, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 3'd1, 3'd1, 2'd1, 5'b00000, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 3'd2, 3'd2, 2'd0, 5'b00100, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 3'd3, 3'd6, 2'd3, 5'b00001, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 3'd4, 3'd3, 2'd1, 5'b11001, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 3'd5, 3'd2, 2'd3, 5'b11111, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 3'd2, 3'd0, 2'd3, 5'b00000, 1'b0, 1'b1, 1'b1};
    repeat (2) @(negedge clk);
    chk("rst_alu", {26'd0, aa, ab}, 0);
    chk("rst_alu_s", 32'(as0), 0);
    chk("rst_rsp", {23'd0, rspv, rid, rr, rsf, rzf, rdzf}, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dz", 32'(dz), 0);
    rst_n = 1;
    // reset in the middle of an operation discards it
    @(negedge clk);
    {r0v, r0a, r0b, r0s} = {1'b1, 3'd3, 3'd1, 2'd0};
    #1 chk("midrst_accept", 32'(r0rdy), 1);
    @(negedge clk);
    r0v = 0; rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("midrst_dz", 32'(dz), 0);
    for (int i = 0; i < 4; i++) begin
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_no_rsp", 32'(rspv), 0);
      @(negedge clk);
    end
    {r0v, r1v} = 2'b11;
    #1 chk("midrst_ptr", {30'd0, r1rdy, r0rdy}, 1);
    {r0v, r1v} = 2'b00;
    // table of single-requester operations
    foreach (tbl[i]) begin
      send(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].s, rsp, lat, w);
      chk($sformatf("tbl%0d_rsp", i), 32'(rsp), {23'd0, tbl[i].id, tbl[i].dzf, tbl[i].zf, tbl[i].sf, tbl[i].r});
      chk($sformatf("tbl%0d_lat", i), lat, 2);
      chk($sformatf("tbl%0d_first_cycle", i), w, 0);
    end
    @(negedge clk);
    chk("tbl_dz", 32'(dz), 1);
    chk("alu_hold", {24'd0, aa, ab, as0}, {24'd0, 3'd2, 3'd0, 2'd3});
    // simultaneous requests alternate starting with requester 0
    do_reset();
    {r0v, r0a, r0b, r0s} = {1'b1, 3'd1, 3'd1, 2'd1};
    {r1v, r1a, r1b, r1s} = {1'b1, 3'd2, 3'd2, 2'd0};
    #1;
    for (int k = 0; k < 6; k++) begin
      w = 0;
      while (!(r0rdy | r1rdy) && w < 20) begin @(negedge clk); #1; w++; end
      chk("sim_grant", {30'd0, r1rdy, r0rdy}, k % 2 ? 2 : 1);
      @(negedge clk);
      w = 0;
      while (!rspv && w < 20) begin @(negedge clk); w++; end
      chk("sim_rsp", {24'd0, rid, rzf, rsf, rr}, k % 2 ? {24'd0, 3'b100, 5'd4} : {24'd0, 3'b010, 5'd0});
      @(negedge clk);
      #1;
    end
    {r0v, r1v} = 2'b00;
    // divide by zero under response backpressure
    @(negedge clk);
    rsp_ready = 0;
    {r0v, r0a, r0b, r0s} = {1'b1, 3'd2, 3'd0, 2'd3};
    #1 chk("dz_accept", 32'(r0rdy), 1);
    dz0 = dz;
    @(negedge clk);
    r0v = 0;
    {r1v, r1a, r1b, r1s} = {1'b1, 3'd1, 3'd1, 2'd0};
    w = 0;
    while (!rspv && w < 20) begin @(negedge clk); w++; end
    snap = {rid, rdzf, rzf, rsf, rr};
    chk("dz_flag", 32'(rdzf), 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("bp_valid", 32'(rspv), 1);
      chk("bp_stable", 32'({rid, rdzf, rzf, rsf, rr}), 32'(snap));
      chk("bp_req1_ready", 32'(r1rdy), 0);
      chk("bp_dz_hold", 32'(dz), 32'(dz0));
    end
    rsp_ready = 1;
    @(negedge clk);
    chk("dz_inc", 32'(dz), 32'(dz0 + 8'd1));
    chk("dz_rsp_done", 32'(rspv), 0);
    #1 chk("dz_next_grant", 32'(r1rdy), 1);
    @(negedge clk);
    r1v = 0;
    w = 0;
    while (!rspv && w < 20) begin @(negedge clk); w++; end
    chk("dz_follow_rsp", {24'd0, rid, rdzf, rr}, {24'd0, 2'b10, 5'd2});
    @(negedge clk);
    chk("dz_no_inc", 32'(dz), 32'(dz0 + 8'd1));
    // randomized traffic against a transaction-level model
    do_reset();
    free = 1; ptr_m = 0; t = 0; dz_m = 0; h0 = 0; h1 = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!free) t++;
      chk("rnd_dz", 32'(dz), dz_m);
      chk("rnd_valid", 32'(rspv), 32'(!free && t >= 2));
      if (!h0) {r0v, r0a, r0b, r0s} = {$urandom_range(0, 2) == 0, 3'($urandom), 3'($urandom), 2'($urandom)};
      if (!h1) {r1v, r1a, r1b, r1s} = {$urandom_range(0, 2) == 0, 3'($urandom), 3'($urandom), 2'($urandom)};
      rsp_ready = $urandom_range(0, 3) != 0;
      #1;
      g1 = r1v && (!r0v || ptr_m);
      e0 = free && r0v && !g1;
      e1 = free && g1;
      chk("rnd_ready", {30'd0, r1rdy, r0rdy}, {30'd0, e1, e0});
      if (!free && t >= 2 && rsp_ready) begin
        snap = q.pop_front();
        chk("rnd_rsp", 32'({rid, rdzf, rzf, rsf, rr}), 32'(snap));
        if (snap[7] && dz_m < 255) dz_m++;
        free = 1;
      end else if (e0 || e1) begin
        q.push_back(g1 ? {1'b1, alu_fn(r1a, r1b, r1s)} : {1'b0, alu_fn(r0a, r0b, r0s)});
        ptr_m = !g1;
        free = 0;
        t = 0;
      end
      h0 = r0v && !e0;
      h1 = r1v && !e1;
    end
    {r0v, r1v} = 2'b00;
    rsp_ready = 1;
    // EXEC_CYCLES=3 / 2-bit counter instance
    for (int k = 0; k < 5; k++) begin
      esend(3'd2, 3'd0, 2'd3, ersp, lat);
      @(negedge clk);
      chk("sat_dz", 32'(e_dz), k < 3 ? k + 1 : 3);
    end
    esend(3'd3, 3'd6, 2'd0, ersp, lat);
    chk("e_add_lat", lat, 4);
    chk("e_add_rsp", 32'(ersp), {24'd0, 3'b000, 5'd1});
    @(negedge clk);
    chk("e_idle", {30'd0, e_busy, e_r1rdy}, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
